// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the parametrised SRAM bank.
//   state_t   - bank controller states (reset hold, clear sweep, ready)
//   DEF_*     - default parameter values for sram_bank / sram_array
//   be_merge  - byte-lane merge: keeps the old byte unless its enable is set
package sram_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_CLEAR_EN = 1;

    // One byte lane of the byte-masked merge; callers loop over the lanes.
    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        logic [7:0] merged;
        if (be) begin
            merged = new_byte;
        end else begin
            merged = old_byte;
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_array.sv
// sram_array: single-port storage with byte-enable write and registered read.
// The storage has no reset so it can map onto block RAM.
//   clk   in  clock
//   we    in  write strobe (word at addr updated at this edge, masked by be)
//   re    in  read strobe (rdata loaded from mem[addr] at this edge)
//   be    in  byte enables for writes
//   addr  in  word address (caller guarantees addr < DEPTH when we/re set)
//   wdata in  write data
//   rdata out registered read data, holds between reads
module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] merged_s;

    // Build the written word lane by lane from current contents and new data.
    always_comb begin
        merged_s = mem_r[addr];
        for (int i = 0; i < BE_W; i++) begin
            merged_s[i*8 +: 8] = be_merge(mem_r[addr][i*8 +: 8], wdata[i*8 +: 8], be[i]);
        end
    end

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= merged_s;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sram_bank.sv
// sram_bank: parametrised single-port SRAM bank with valid/ready requests,
// byte-enable writes, RD_LAT (1 or 2) cycle reads and a post-reset clear sweep.
//   clk        in  clock
//   res_n      in  async active-low reset (flops only, not the array)
//   req_valid  in  request present
//   req_ready  out request accepted this cycle (READY state only)
//   req_we     in  1 = write, 0 = read
//   req_be     in  byte enables for writes
//   req_addr   in  word address
//   req_wdata  in  write data
//   rsp_valid  out one-cycle read response pulse
//   rsp_rdata  out read data, holds when rsp_valid = 0
//   rsp_err    out read address was out of range (only with rsp_valid)
//   busy       out clear sweep in progress
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int CLEAR_EN = DEF_CLEAR_EN
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    state_t             state_r, next_s;
    logic [ADDR_W-1:0]  clr_cnt_r, clr_cnt_nxt_s;
    logic               ready_r, busy_r;
    logic               accept_s, in_range_s;
    logic               arr_we_s, arr_re_s;
    logic [BE_W-1:0]    arr_be_s;
    logic [ADDR_W-1:0]  arr_addr_s;
    logic [DATA_W-1:0]  arr_wdata_s, arr_rdata_s;
    logic               rd_v1_r, rd_e1_r;
    logic [DATA_W-1:0]  st1_data_s;
    logic               pre_v_s, pre_e_s;
    logic [DATA_W-1:0]  pre_d_s;
    logic               rsp_valid_r, rsp_err_r;
    logic [DATA_W-1:0]  rsp_rdata_r;

    assign accept_s   = req_valid & ready_r;
    // Compare at 32 bits so DEPTH == 2**ADDR_W does not wrap to zero.
    assign in_range_s = (32'(req_addr) < 32'(DEPTH));

    // Next-state and clear-counter logic.
    always_comb begin
        next_s        = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_RESET: begin
                if (CLEAR_EN != 0) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_READY;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == ADDR_W'(DEPTH - 1)) begin
                    next_s        = ST_READY;
                    clr_cnt_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            ST_READY: begin
                next_s = ST_READY;
            end
            default: begin
                next_s        = ST_RESET;
                clr_cnt_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Array port mux: the sweep owns the port while clearing, requests otherwise.
    always_comb begin
        if (state_r == ST_CLEAR) begin
            arr_we_s    = 1'b1;
            arr_re_s    = 1'b0;
            arr_be_s    = {BE_W{1'b1}};
            arr_addr_s  = clr_cnt_r;
            arr_wdata_s = {DATA_W{1'b0}};
        end else begin
            arr_we_s    = accept_s & req_we & in_range_s;
            arr_re_s    = accept_s & ~req_we & in_range_s;
            arr_be_s    = req_be;
            arr_addr_s  = req_addr;
            arr_wdata_s = req_wdata;
        end
    end

    // Controller state, registered handshake outputs and read-issue stage.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r   <= ST_RESET;
            clr_cnt_r <= {ADDR_W{1'b0}};
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            rd_v1_r   <= 1'b0;
            rd_e1_r   <= 1'b0;
        end else begin
            state_r   <= next_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            ready_r   <= (next_s == ST_READY);
            busy_r    <= (next_s == ST_CLEAR);
            rd_v1_r   <= accept_s & ~req_we;
            rd_e1_r   <= accept_s & ~req_we & ~in_range_s;
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .be    (arr_be_s),
        .addr  (arr_addr_s),
        .wdata (arr_wdata_s),
        .rdata (arr_rdata_s)
    );

    // Out-of-range reads never touch the array and return zero.
    always_comb begin
        if (rd_e1_r) begin
            st1_data_s = {DATA_W{1'b0}};
        end else begin
            st1_data_s = arr_rdata_s;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              v2_r, e2_r;
        logic [DATA_W-1:0] d2_r;

        // Extra pipeline stage for two-cycle read latency.
        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                v2_r <= 1'b0;
                e2_r <= 1'b0;
                d2_r <= {DATA_W{1'b0}};
            end else begin
                v2_r <= rd_v1_r;
                e2_r <= rd_e1_r;
                if (rd_v1_r) begin
                    d2_r <= st1_data_s;
                end
            end
        end

        assign pre_v_s = v2_r;
        assign pre_e_s = e2_r;
        assign pre_d_s = d2_r;
    end else begin : g_lat1
        assign pre_v_s = rd_v1_r;
        assign pre_e_s = rd_e1_r;
        assign pre_d_s = st1_data_s;
    end

    // Response output register; data holds between responses.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rsp_valid_r <= pre_v_s;
            rsp_err_r   <= pre_v_s & pre_e_s;
            if (pre_v_s) begin
                rsp_rdata_r <= pre_d_s;
            end
        end
    end

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule
